// File: rtl/t16_pkg.sv
// Shared T16 datapath types: ALU opcode, ALU flag bundle and default
// register-file geometry.
package t16_pkg;

  localparam int T16_NREGS = 8;
  localparam int T16_WIDTH = 16;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SHL  = 3'd5,
    ALU_SHR  = 3'd6,
    ALU_PASS = 3'd7
  } ALUOp;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } ALUFlags;

endpackage

// File: rtl/t16_regfile.sv
// T16 register file: r0 hard-wired to zero, registered operand pair to the ALU,
// architectural flags. Define T16_REGFILE_BYPASS_EN to forward same-edge writeback.
module t16_regfile
  import t16_pkg::*;
#(
  parameter int NREGS = T16_NREGS,
  parameter int WIDTH = T16_WIDTH,
  localparam int AW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  input  logic             stall,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] s2,
  output logic             op_valid,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             flags_en,
  input  ALUFlags          flags_in,
  output ALUFlags          flags
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
  logic             vld_q, vld_d;
  ALUFlags          flags_q, flags_d;
  logic [WIDTH-1:0] rd1, rd2;
  logic             wr_ok;

  // Index 0 and anything past NREGS are not backed by storage.
  function automatic logic live(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREGS);
  endfunction

  assign wr_ok = wb_en && live(wb_addr);

  always_comb begin
    rd1 = live(rs1_addr) ? regs_q[rs1_addr] : '0;
    rd2 = live(rs2_addr) ? regs_q[rs2_addr] : '0;
`ifdef T16_REGFILE_BYPASS_EN
    if (wr_ok && (wb_addr == rs1_addr)) rd1 = wb_data;
    if (wr_ok && (wb_addr == rs2_addr)) rd2 = wb_data;
`endif
  end

  always_comb begin
    regs_d  = regs_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    vld_d   = vld_q;
    flags_d = flags_q;
    if (wr_ok)    regs_d[wb_addr] = wb_data;
    if (flags_en) flags_d = flags_in;
    // Stall freezes the operand stage only; writeback and flags keep flowing.
    if (!stall) begin
      vld_d = rd_en;
      if (rd_en) begin
        s1_d = rd1;
        s2_d = rd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      vld_q   <= 1'b0;
      flags_q <= '0;
    end else begin
      regs_q  <= regs_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      vld_q   <= vld_d;
      flags_q <= flags_d;
    end
  end

  assign s1       = s1_q;
  assign s2       = s2_q;
  assign op_valid = vld_q;
  assign flags    = flags_q;

endmodule
